ask_threshold_ctrl: RTL and testbench

- Adaptive slicing-threshold controller and decision stage for the ASK path, placed directly after the AM envelope demodulator.
- Measures envelope min/max over a fixed sample window, computes the midpoint threshold, and slices the envelope into the two fixed output levels used downstream.
- Supports single-shot or continuous re-acquisition and flags windows whose swing is too small to trust.

---
 rtl/ask_threshold_ctrl_if.sv | 25 ++
 rtl/ask_threshold_ctrl.sv | 153 +++++++++++++++
 tb/tb_ask_threshold_ctrl.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ask_threshold_ctrl_if.sv
// Signal bundle between the AM envelope demodulator side and the ASK threshold controller.
// master drives envelope samples and control; slave (the controller) returns threshold, status and sliced level.
interface ask_threshold_ctrl_if #(
  parameter int IO_width = 14
);
  logic                       sample_valid;
  logic signed [IO_width-1:0] AM_demod;
  logic                       start;
  logic                       continuous;
  logic signed [IO_width-1:0] threshold_out;
  logic                       thr_valid;
  logic                       low_swing;
  logic                       busy;
  logic signed [IO_width-1:0] ASK_out;

  modport master (
    output sample_valid, AM_demod, start, continuous,
    input  threshold_out, thr_valid, low_swing, busy, ASK_out
  );

  modport slave (
    input  sample_valid, AM_demod, start, continuous,
    output threshold_out, thr_valid, low_swing, busy, ASK_out
  );
endinterface

// File: rtl/ask_threshold_ctrl.sv
// Adaptive min/max midpoint slicer for the ASK envelope; decision latency 2 edges, no backpressure.
// Optional hysteresis around the threshold is enabled with macro ASK_HYST_EN.
module ask_threshold_ctrl #(
  parameter int                         IO_width    = 14,
  parameter int                         WIN_W       = 10,
  parameter logic signed [IO_width-1:0] DEFAULT_THR = 14'sd3500,
  parameter logic signed [IO_width-1:0] MIN_SWING   = 14'sd400,
  parameter logic signed [IO_width-1:0] HIGH_LVL    = 14'sd5500,
  parameter logic signed [IO_width-1:0] LOW_LVL     = 14'sd100,
  parameter logic signed [IO_width-1:0] HYST        = 14'sd200
) (
  input  logic                clk,
  input  logic                rst_n,
  ask_threshold_ctrl_if.slave io
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACQ  = 2'd1,
    CALC = 2'd2
  } state_t;

  localparam logic signed [IO_width-1:0] POS_MAX = {1'b0, {(IO_width-1){1'b1}}};
  localparam logic signed [IO_width-1:0] NEG_MAX = {1'b1, {(IO_width-1){1'b0}}};
  localparam logic signed [IO_width:0]   MIN_SWING_X = {MIN_SWING[IO_width-1], MIN_SWING};

  state_t                     state_q, state_d;
  logic [WIN_W-1:0]           count_q, count_d;
  logic signed [IO_width-1:0] min_q, min_d;
  logic signed [IO_width-1:0] max_q, max_d;
  logic signed [IO_width-1:0] thr_q, thr_d;
  logic                       thr_vld_q, thr_vld_d;
  logic                       low_q, low_d;
  logic signed [IO_width-1:0] samp_q;
  logic                       samp_vld_q;
  logic signed [IO_width-1:0] ask_q, ask_d;

  // One extra bit keeps both the swing and the midpoint sum free of overflow.
  logic signed [IO_width:0] max_x, min_x, swing, sum;
  assign max_x = {max_q[IO_width-1], max_q};
  assign min_x = {min_q[IO_width-1], min_q};
  assign swing = max_x - min_x;
  assign sum   = max_x + min_x;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      count_q    <= '0;
      min_q      <= POS_MAX;
      max_q      <= NEG_MAX;
      thr_q      <= DEFAULT_THR;
      thr_vld_q  <= 1'b0;
      low_q      <= 1'b0;
      samp_q     <= '0;
      samp_vld_q <= 1'b0;
      ask_q      <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      min_q      <= min_d;
      max_q      <= max_d;
      thr_q      <= thr_d;
      thr_vld_q  <= thr_vld_d;
      low_q      <= low_d;
      samp_vld_q <= io.sample_valid;
      if (io.sample_valid) begin
        samp_q <= io.AM_demod;
      end
      ask_q      <= ask_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    min_d     = min_q;
    max_d     = max_q;
    thr_d     = thr_q;
    thr_vld_d = thr_vld_q;
    low_d     = low_q;
    case (state_q)
      IDLE: begin
        if (io.start) begin
          state_d = ACQ;
          count_d = '0;
          min_d   = POS_MAX;
          max_d   = NEG_MAX;
        end
      end
      ACQ: begin
        // A restart drops the sample presented in the same cycle.
        if (io.start) begin
          count_d = '0;
          min_d   = POS_MAX;
          max_d   = NEG_MAX;
        end else if (io.sample_valid) begin
          if (io.AM_demod < min_q) min_d = io.AM_demod;
          if (io.AM_demod > max_q) max_d = io.AM_demod;
          count_d = count_q + WIN_W'(1);
          if (count_q == {WIN_W{1'b1}}) begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (swing < MIN_SWING_X) begin
          low_d = 1'b1;
        end else begin
          thr_d     = sum[IO_width:1];
          low_d     = 1'b0;
          thr_vld_d = 1'b1;
        end
        count_d = '0;
        min_d   = POS_MAX;
        max_d   = NEG_MAX;
        state_d = io.continuous ? ACQ : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef ASK_HYST_EN
  logic signed [IO_width:0] samp_x, thr_x, hyst_x, thr_hi, thr_lo;
  assign samp_x = {samp_q[IO_width-1], samp_q};
  assign thr_x  = {thr_q[IO_width-1], thr_q};
  assign hyst_x = {HYST[IO_width-1], HYST};
  assign thr_hi = thr_x + hyst_x;
  assign thr_lo = thr_x - hyst_x;
`endif

  always_comb begin
    ask_d = ask_q;
    if (samp_vld_q) begin
`ifdef ASK_HYST_EN
      // Before any decision ASK_out is 0, which falls to the plain compare.
      case (ask_q)
        HIGH_LVL: ask_d = (samp_x > thr_hi)  ? LOW_LVL  : HIGH_LVL;
        LOW_LVL:  ask_d = (samp_x <= thr_lo) ? HIGH_LVL : LOW_LVL;
        default:  ask_d = (samp_q <= thr_q)  ? HIGH_LVL : LOW_LVL;
      endcase
`else
      ask_d = (samp_q <= thr_q) ? HIGH_LVL : LOW_LVL;
`endif
    end
  end

  assign io.threshold_out = thr_q;
  assign io.thr_valid     = thr_vld_q;
  assign io.low_swing     = low_q;
  assign io.busy          = (state_q != IDLE);
  assign io.ASK_out       = ask_q;

endmodule

// File: tb/tb_ask_threshold_ctrl.sv
// Bench for ask_threshold_ctrl (WIN_W=4): directed steps then random traffic, every cycle compared to a window-level model.
module tb_ask_threshold_ctrl;

  localparam int WIN  = 16;
  localparam int HIGH = 5500;
  localparam int LOW  = 100;
  localparam int DTHR = 3500;
  localparam int MSW  = 400;
  localparam int HYS  = 200;

  logic clk;
  logic rst_n;

  ask_threshold_ctrl_if #(.IO_width(14)) bus ();

  ask_threshold_ctrl #(.IO_width(14), .WIN_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state: threshold/status, collected window samples, pending decision.
  int  m_thr;
  int  exp_ask;
  bit  m_tv, m_low, m_acq, m_calc;
  bit  pend_vld;
  int  pend_dat;
  int  win[$];

  task automatic chk(string tag, int obs, int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int decide(int d);
`ifdef ASK_HYST_EN
    if (exp_ask == HIGH) return (d > m_thr + HYS) ? LOW : HIGH;
    if (exp_ask == LOW)  return (d <= m_thr - HYS) ? HIGH : LOW;
`endif
    return (d <= m_thr) ? HIGH : LOW;
  endfunction

  task automatic model_reset();
    m_thr = DTHR; exp_ask = 0; m_tv = 0; m_low = 0;
    m_acq = 0; m_calc = 0; pend_vld = 0; pend_dat = 0;
    win.delete();
  endtask

  task automatic model_edge(bit v, int d, bit st, bit cont);
    int mn, mx;
    if (pend_vld) exp_ask = decide(pend_dat);
    pend_vld = v;
    pend_dat = d;
    if (m_calc) begin
      mn = win[0];
      mx = win[0];
      foreach (win[i]) begin
        if (win[i] < mn) mn = win[i];
        if (win[i] > mx) mx = win[i];
      end
      if (mx - mn < MSW) m_low = 1;
      else begin
        m_thr = (mx + mn) >>> 1;
        m_low = 0;
        m_tv  = 1;
      end
      m_calc = 0;
      m_acq  = cont;
      win.delete();
    end else if (m_acq) begin
      if (st) win.delete();
      else if (v) begin
        win.push_back(d);
        if (win.size() == WIN) begin
          m_calc = 1;
          m_acq  = 0;
        end
      end
    end else if (st) begin
      m_acq = 1;
      win.delete();
    end
  endtask

  task automatic check_all();
    chk("ask_out",   int'(bus.ASK_out),       exp_ask);
    chk("threshold", int'(bus.threshold_out), m_thr);
    chk("thr_valid", int'(bus.thr_valid),     int'(m_tv));
    chk("low_swing", int'(bus.low_swing),     int'(m_low));
    chk("busy",      int'(bus.busy),          int'(m_acq | m_calc));
  endtask

  task automatic step(bit v, int d, bit st, bit cont);
    bus.sample_valid = v;
    bus.AM_demod     = d[13:0];
    bus.start        = st;
    bus.continuous   = cont;
    @(posedge clk);
    model_edge(v, d, st, cont);
    #1;
    check_all();
  endtask

  task automatic send_chk(int d, int exp, string tag);
    step(1'b1, d, 1'b0, 1'b0);
    step(1'b0, 0, 1'b0, 1'b0);
    chk(tag, int'(bus.ASK_out), exp);
  endtask

  // 16 counted samples: first a, second b, rest random in [a,b]; random idle gaps.
  task automatic win_samples(int a, int b, bit cont, bit alt);
    int val;
    for (int i = 0; i < WIN; i++) begin
      if ($urandom_range(0, 2) == 0) step(1'b0, $urandom_range(0, 8000), 1'b0, cont);
      if (alt)         val = (i % 2 == 0) ? a : b;
      else if (i == 0) val = a;
      else if (i == 1) val = b;
      else             val = a + int'($urandom_range(0, b - a));
      step(1'b1, val, 1'b0, cont);
    end
  endtask

  task automatic send_win(int a, int b, bit alt);
    step(1'b0, 0, 1'b1, 1'b0);
    win_samples(a, b, 1'b0, alt);
    step(1'b0, 0, 1'b0, 1'b0);
  endtask

  initial begin
    int span, base;
    bit cont;
    int hexp[4];

    rst_n = 1'b0;
    bus.sample_valid = 1'b0;
    bus.AM_demod     = '0;
    bus.start        = 1'b0;
    bus.continuous   = 1'b0;
    model_reset();
    #12;
    chk("rst_ask", int'(bus.ASK_out), 0);
    chk("rst_thr", int'(bus.threshold_out), 3500);
    chk("rst_tv",  int'(bus.thr_valid), 0);
    chk("rst_low", int'(bus.low_swing), 0);
    chk("rst_busy", int'(bus.busy), 0);
    rst_n = 1'b1;

    // Default threshold, 2-edge latency
    step(1'b1, 3500, 1'b0, 1'b0);
    chk("lat_first_still0", int'(bus.ASK_out), 0);
    step(1'b0, 0, 1'b0, 1'b0);
    chk("dflt_3500_high", int'(bus.ASK_out), 5500);
    send_chk(3501, 100, "dflt_3501_low");
    chk("dflt_thr_valid", int'(bus.thr_valid), 0);

    // Single window 1000/5000
    send_win(1000, 5000, 1'b1);
    chk("w1_thr", int'(bus.threshold_out), 3000);
    chk("w1_tv", int'(bus.thr_valid), 1);
    chk("w1_low", int'(bus.low_swing), 0);
    chk("w1_idle", int'(bus.busy), 0);
    send_chk(3000, 5500, "w1_eq_high");
    send_chk(3001, 100, "w1_above_low");

    // Low swing then good window
    send_win(2000, 2300, 1'b0);
    chk("ls_thr_kept", int'(bus.threshold_out), 3000);
    chk("ls_flag", int'(bus.low_swing), 1);
    send_win(0, 4000, 1'b1);
    chk("ls_recover_thr", int'(bus.threshold_out), 2000);
    chk("ls_recover_flag", int'(bus.low_swing), 0);

    // Continuous: back-to-back windows, sample in CALC not counted, cont dropped mid-window
    step(1'b0, 0, 1'b1, 1'b1);
    win_samples(1000, 5000, 1'b1, 1'b1);
    step(1'b1, 7000, 1'b0, 1'b1);
    chk("cont_thr1", int'(bus.threshold_out), 3000);
    chk("cont_busy", int'(bus.busy), 1);
    win_samples(-3000, -1000, 1'b0, 1'b1);
    step(1'b0, 0, 1'b0, 1'b0);
    chk("neg_thr", int'(bus.threshold_out), -2000);
    chk("cont_end_idle", int'(bus.busy), 0);

    send_win(-8192, 8191, 1'b1);
    chk("extreme_thr", int'(bus.threshold_out), -1);

    // Restart after 7 samples
    step(1'b0, 0, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b1, -8192, 1'b0, 1'b0);
    step(1'b1, 8191, 1'b1, 1'b0);
    win_samples(0, 4000, 1'b0, 1'b1);
    chk("restart_calc_busy", int'(bus.busy), 1);
    step(1'b0, 0, 1'b0, 1'b0);
    chk("restart_thr", int'(bus.threshold_out), 2000);

    // Async reset mid-window
    step(1'b0, 0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 6000, 1'b0, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_ask", int'(bus.ASK_out), 0);
    chk("mid_rst_thr", int'(bus.threshold_out), 3500);
    chk("mid_rst_tv", int'(bus.thr_valid), 0);
    chk("mid_rst_low", int'(bus.low_swing), 0);
    chk("mid_rst_busy", int'(bus.busy), 0);
    model_reset();
    #2 rst_n = 1'b1;

    // Hysteresis sequence around 3000
    send_win(1000, 5000, 1'b1);
    send_chk(2000, 5500, "hy_pre_high");
`ifdef ASK_HYST_EN
    hexp = '{5500, 100, 100, 5500};
`else
    hexp = '{100, 100, 5500, 5500};
`endif
    send_chk(3100, hexp[0], "hy_3100");
    send_chk(3201, hexp[1], "hy_3201");
    send_chk(2900, hexp[2], "hy_2900");
    send_chk(2799, hexp[3], "hy_2799");

    // Random traffic, alternating wide and narrow data ranges
    for (int blk = 0; blk < 8; blk++) begin
      cont = 1'($urandom_range(0, 1));
      if (blk % 2 == 0) begin
        span = 16383;
        base = -8192;
      end else begin
        span = 300;
        base = int'($urandom_range(0, 6000)) - 3000;
      end
      step(1'b0, 0, 1'b1, cont);
      for (int c = 0; c < 60; c++) begin
        step(1'($urandom_range(0, 1)), base + int'($urandom_range(0, span)),
             ($urandom_range(0, 29) == 0), cont);
      end
    end
    for (int c = 0; c < 40; c++) step(1'b0, 0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
